// File: rtl/fifo_read_sched_pkg.sv
// Shared types and defaults for the FIFO read-side scheduler.
// State encodings are visible on the debug port, so they are fixed here.
package fifo_read_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WAIT   = 3'd2,
        LAUNCH = 3'd3,
        ACK    = 3'd4,
        DRAIN  = 3'd5,
        GAP    = 3'd6
    } state_t;

    localparam int RD_LAT_DEF      = 1;
    localparam int ACK_TIMEOUT_DEF = 1024;
    localparam int GAP_CYC_DEF     = 2;

    localparam int LAT_W = 3;
    localparam int GAP_W = 4;

    function automatic int tmo_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser.
// Async active-high reset clears both stages.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_read_sched.sv
// Read-side scheduler: pops one frame at a time from the async FIFO
// and waits for the serial output stage to finish before the next pop.
module fifo_read_sched
    import fifo_read_sched_pkg::*;
#(
    parameter int RD_LAT      = RD_LAT_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int GAP_CYC     = GAP_CYC_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk_out,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic             data_count_zero,
    input  logic             out_busy,
    output logic             fifo_r_enable,
    output logic             frame_start,
    output logic             sched_busy,
    output logic [CNT_W-1:0] frames_sent,
    output logic             timeout_err,
    output logic [2:0]       state_o
);

    localparam int TMO_W = tmo_width(ACK_TIMEOUT);

    state_t state, state_n;

    logic [LAT_W-1:0] lat_cnt, lat_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic             busy_s;
    logic             tmo_hit;
    logic             count;
    logic             tmo_set;

    sync_2ff u_busy_sync (
        .clk (clk_out),
        .rst (rst),
        .d   (out_busy),
        .q   (busy_s)
    );

    assign tmo_hit = (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));
    assign state_o = state;

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (enable && !fifo_empty) state_n = READ;
            READ:    state_n = WAIT;
            WAIT:    if (lat_cnt == '0) state_n = LAUNCH;
            LAUNCH:  state_n = data_count_zero ? GAP : ACK;
            ACK: begin
                if (busy_s)       state_n = DRAIN;
                else if (tmo_hit) state_n = GAP;
            end
            DRAIN:   if (!busy_s || tmo_hit) state_n = GAP;
            GAP:     if (gap_cnt <= GAP_W'(1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        lat_n   = lat_cnt;
        tmo_n   = tmo_cnt;
        gap_n   = gap_cnt;
        count   = 1'b0;
        tmo_set = 1'b0;
        unique case (state)
            READ: lat_n = LAT_W'(RD_LAT - 1);
            WAIT: if (lat_cnt != '0) lat_n = lat_cnt - LAT_W'(1);
            LAUNCH: begin
                tmo_n = '0;
                count = data_count_zero;
            end
            ACK: begin
                if (busy_s)       tmo_n = '0;
                else if (tmo_hit) tmo_set = 1'b1;
                else              tmo_n = tmo_cnt + TMO_W'(1);
            end
            DRAIN: begin
                if (!busy_s)      count = 1'b1;
                else if (tmo_hit) tmo_set = 1'b1;
                else              tmo_n = tmo_cnt + TMO_W'(1);
            end
            GAP: if (gap_cnt != '0) gap_n = gap_cnt - GAP_W'(1);
            default: ;
        endcase
        // GAP_CYC=0 still spends one cycle in GAP before IDLE
        if (state_n == GAP && state != GAP) gap_n = GAP_W'(GAP_CYC);
    end

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            lat_cnt       <= '0;
            tmo_cnt       <= '0;
            gap_cnt       <= '0;
            fifo_r_enable <= 1'b0;
            frame_start   <= 1'b0;
            sched_busy    <= 1'b0;
            frames_sent   <= '0;
            timeout_err   <= 1'b0;
        end else begin
            lat_cnt       <= lat_n;
            tmo_cnt       <= tmo_n;
            gap_cnt       <= gap_n;
            fifo_r_enable <= (state_n == READ);
            frame_start   <= (state_n == LAUNCH);
            sched_busy    <= (state_n != IDLE);
            if (count)   frames_sent <= frames_sent + CNT_W'(1);
            if (tmo_set) timeout_err <= 1'b1;
        end
    end

endmodule
